// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU pipeline types and sizing constants.
package tinycpu_pkg;

  localparam int unsigned NREGS        = 32;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned RW           = $clog2(NREGS);
  localparam int unsigned CW           = 3;

  typedef logic [RW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_DRAIN,
    SB_DONE
  } sb_state_e;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW hazard check for one issue slot against the pending-write vector.
module sb_hazard_check
  import tinycpu_pkg::*;
(
  input  logic [NREGS-1:0] busy,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_rd,
  input  logic [RW-1:0]    rs1,
  input  logic             rs1_used,
  input  logic [RW-1:0]    rs2,
  input  logic             rs2_used,
  input  logic [RW-1:0]    rd,
  input  logic             rd_we,
  output logic             hazard
);

  logic [NREGS-1:0] eb;

  // Effective busy: a same-cycle writeback resolves the hazard (write-first regfile).
  always_comb begin
    eb = busy;
    if (wb_valid) begin
      eb[wb_rd] = 1'b0;
    end
    eb[0] = 1'b0;
  end

  // Source reads (RAW) and destination (WAW) against the effective busy vector.
  always_comb begin
    hazard = (rs1_used && eb[rs1]) ||
             (rs2_used && eb[rs2]) ||
             (rd_we && (rd != '0) && eb[rd]);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: pending-write tracking, in-flight limit, fence drain.
module issue_scoreboard
  import tinycpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_rd_we,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_rd,
  input  logic             retire_valid,
  input  logic             fence_req,
  output logic             stall,
  output logic             issue_fire,
  output logic             fence_done,
  output logic [CW-1:0]    inflight,
  output logic [NREGS-1:0] busy,
  output logic             err
);

  sb_state_e        state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;
  logic             hazard;
  logic             full;

  sb_hazard_check u_hazard (
    .busy     (busy_q),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .rs1      (issue_rs1),
    .rs1_used (issue_rs1_used),
    .rs2      (issue_rs2),
    .rs2_used (issue_rs2_used),
    .rd       (issue_rd),
    .rd_we    (issue_rd_we),
    .hazard   (hazard)
  );

  // Stall/fire decision; a same-cycle retire frees a slot when the pipe is full.
  always_comb begin
    full       = (inflight_q == CW'(MAX_INFLIGHT)) && !retire_valid;
    stall      = issue_valid && (hazard || full || (state_q != SB_RUN) || fence_req);
    issue_fire = issue_valid && !stall;
    fence_done = (state_q == SB_DONE);
  end

  // Pending-write vector: writeback clears, issue sets, set wins, r0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_fire && issue_rd_we && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // In-flight counter and sticky protocol error.
  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    case ({issue_fire, retire_valid})
      2'b10: inflight_d = inflight_q + 1'b1;
      2'b01: begin
        if (inflight_q == '0) begin
          err_d = 1'b1;
        end else begin
          inflight_d = inflight_q - 1'b1;
        end
      end
      default: ;
    endcase
    if (wb_valid && (wb_rd != '0) && !busy_q[wb_rd]) begin
      err_d = 1'b1;
    end
  end

  // Fence FSM next state: drain until the pipe is empty, then pulse done for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (fence_req) state_d = SB_DRAIN;
      SB_DRAIN: if ((inflight_q == '0) && (busy_q == '0)) state_d = SB_DONE;
      SB_DONE:  state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  // State registers with synchronous reset; reset mid-drain simply returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SB_RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight = inflight_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
